cam_fifo_sync: RTL and testbench

Parametrised single-clock FIFO that buffers camera pixel bytes between the capture front end and downstream consumers.
- Adds an occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a read-valid strobe.
- An optional first-word-fall-through read mode is selectable at compile time.
- Sits directly behind the camera capture logic in the Pclk domain.

---
 rtl/cam_fifo_sync.sv | 104 ++++++++++
 tb/tb_cam_fifo_sync.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/cam_fifo_sync.sv
// Single-clock pixel FIFO with occupancy level, almost-full/empty thresholds and sticky error flags.
// Optional first-word-fall-through read path enabled by defining CAM_FIFO_FWFT_EN.
module cam_fifo_sync #(
   parameter int ADR_WIDTH = 4,
   parameter int DAT_WIDTH = 8,
   parameter int AF_THRESH = (1 << ADR_WIDTH) - 2,
   parameter int AE_THRESH = 1
) (
   input  logic                 Pclk,
   input  logic                 rst,
   input  logic                 wr,
   input  logic [DAT_WIDTH-1:0] data_in,
   input  logic                 rd,
   input  logic                 clr_err,
   output logic [DAT_WIDTH-1:0] data_out,
   output logic                 rd_valid,
   output logic                 empty,
   output logic                 full,
   output logic                 almost_full,
   output logic                 almost_empty,
   output logic [ADR_WIDTH:0]   level,
   output logic                 overflow,
   output logic                 underflow
);

   localparam int DEPTH = 1 << ADR_WIDTH;
   localparam logic [ADR_WIDTH:0] DEPTH_L = (ADR_WIDTH+1)'(DEPTH);
   localparam logic [ADR_WIDTH:0] AF_L    = (ADR_WIDTH+1)'(AF_THRESH);
   localparam logic [ADR_WIDTH:0] AE_L    = (ADR_WIDTH+1)'(AE_THRESH);

   logic [DAT_WIDTH-1:0] mem [DEPTH];
   logic [ADR_WIDTH-1:0] w_ptr;
   logic [ADR_WIDTH-1:0] r_ptr;
   logic [ADR_WIDTH:0]   level_nxt;
   logic                 wa;
   logic                 ra;

   // Acceptance looks only at the registered flags, so wr/rd never reach the flags combinationally.
   assign wa = wr & ~full;
   assign ra = rd & ~empty;

   always_comb begin
      level_nxt = level;
      case ({wa, ra})
         2'b10:   level_nxt = level + 1'b1;
         2'b01:   level_nxt = level - 1'b1;
         default: level_nxt = level;
      endcase
   end

   always_ff @(posedge Pclk) begin
      if (wa && !rst) begin
         mem[w_ptr] <= data_in;
      end
   end

   always_ff @(posedge Pclk) begin
      if (rst) begin
         w_ptr        <= '0;
         r_ptr        <= '0;
         level        <= '0;
         empty        <= 1'b1;
         full         <= 1'b0;
         almost_full  <= (AF_L == '0);
         almost_empty <= 1'b1;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         if (wa) begin
            w_ptr <= w_ptr + 1'b1;
         end
         if (ra) begin
            r_ptr <= r_ptr + 1'b1;
         end
         level        <= level_nxt;
         empty        <= (level_nxt == '0);
         full         <= (level_nxt == DEPTH_L);
         almost_full  <= (level_nxt >= AF_L);
         almost_empty <= (level_nxt <= AE_L);
         // A fresh error in the same cycle as clr_err wins over the clear.
         overflow     <= (overflow  & ~clr_err) | (wr & full);
         underflow    <= (underflow & ~clr_err) | (rd & empty);
      end
   end

`ifdef CAM_FIFO_FWFT_EN
   // Head word is shown directly; forced to zero while empty so stale memory never leaks out.
   assign data_out = empty ? '0 : mem[r_ptr];
   assign rd_valid = ~empty;
`else
   always_ff @(posedge Pclk) begin
      if (rst) begin
         data_out <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= ra;
         if (ra) begin
            data_out <= mem[r_ptr];
         end
      end
   end
`endif

endmodule

// File: tb/tb_cam_fifo_sync.sv
// Self-checking bench for cam_fifo_sync: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_cam_fifo_sync;
   localparam int AW    = 3;
   localparam int DW    = 8;
   localparam int DEPTH = 8;
   localparam int AF    = 6;
   localparam int AE    = 1;

   logic          Pclk = 1'b0;
   logic          rst = 1'b0;
   logic          wr = 1'b0;
   logic          rd = 1'b0;
   logic          clr_err = 1'b0;
   logic [DW-1:0] data_in = '0;
   logic [DW-1:0] data_out;
   logic          rd_valid, empty, full, almost_full, almost_empty, overflow, underflow;
   logic [AW:0]   level;

   int n_checks = 0;
   int n_fail   = 0;
   bit check_en = 1'b0;

   bit [7:0] q[$];
   bit       m_ov, m_un, m_rv;
   bit [7:0] m_dout;

   cam_fifo_sync #(.ADR_WIDTH(AW), .DAT_WIDTH(DW), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
      .Pclk(Pclk), .rst(rst), .wr(wr), .data_in(data_in), .rd(rd), .clr_err(clr_err),
      .data_out(data_out), .rd_valid(rd_valid), .empty(empty), .full(full),
      .almost_full(almost_full), .almost_empty(almost_empty), .level(level),
      .overflow(overflow), .underflow(underflow)
   );

   always #5 Pclk = ~Pclk;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: occupancy is simply the queue size; errors judged on pre-edge occupancy.
   always @(posedge Pclk) begin
      if (rst) begin
         q.delete();
         m_ov = 1'b0;
         m_un = 1'b0;
         m_rv = 1'b0;
         m_dout = 8'h00;
      end else begin
         bit was_full, was_empty;
         was_full  = (q.size() == DEPTH);
         was_empty = (q.size() == 0);
         if (clr_err) begin
            m_ov = 1'b0;
            m_un = 1'b0;
         end
         if (wr && was_full)  m_ov = 1'b1;
         if (rd && was_empty) m_un = 1'b1;
         m_rv = 1'b0;
         if (rd && !was_empty) begin
            m_dout = q.pop_front();
            m_rv = 1'b1;
         end
         if (wr && !was_full) q.push_back(data_in);
      end
   end

   always @(negedge Pclk) begin
      if (check_en) begin
         check("level", int'(level), q.size());
         check("empty", int'(empty), int'(q.size() == 0));
         check("full", int'(full), int'(q.size() == DEPTH));
         check("almost_full", int'(almost_full), int'(q.size() >= AF));
         check("almost_empty", int'(almost_empty), int'(q.size() <= AE));
         check("overflow", int'(overflow), int'(m_ov));
         check("underflow", int'(underflow), int'(m_un));
`ifdef CAM_FIFO_FWFT_EN
         check("rd_valid", int'(rd_valid), int'(q.size() != 0));
         check("data_out", int'(data_out), (q.size() != 0) ? int'(q[0]) : 0);
`else
         check("rd_valid", int'(rd_valid), int'(m_rv));
         check("data_out", int'(data_out), int'(m_dout));
`endif
      end
   end

   task automatic step(input bit w, input logic [7:0] d, input bit r, input bit c, input bit rs);
      wr = w;
      data_in = d;
      rd = r;
      clr_err = c;
      rst = rs;
      @(posedge Pclk);
      @(negedge Pclk);
      #1;
   endtask

   initial begin
      step(0, 8'h00, 0, 0, 1);
      check_en = 1'b1;
      step(0, 8'h00, 0, 0, 0);
      check("t1_empty", int'(empty), 1);
      check("t1_full", int'(full), 0);
      check("t1_level", int'(level), 0);
      check("t1_almost_empty", int'(almost_empty), 1);
      check("t1_almost_full", int'(almost_full), 0);
      check("t1_overflow", int'(overflow), 0);
      check("t1_underflow", int'(underflow), 0);
      check("t1_rd_valid", int'(rd_valid), 0);
      check("t1_data_out", int'(data_out), 0);

`ifdef CAM_FIFO_FWFT_EN
      step(1, 8'h55, 0, 0, 0);
      check("fwft_data_out", int'(data_out), 'h55);
      check("fwft_rd_valid", int'(rd_valid), 1);
      step(0, 8'h00, 1, 0, 0);
      check("fwft_empty", int'(empty), 1);
      check("fwft_rd_valid_low", int'(rd_valid), 0);
`else
      for (int i = 0; i < 8; i++) begin
         step(1, 8'(8'h10 + i), 0, 0, 0);
         if (i == 4) check("t2_af_at5", int'(almost_full), 0);
         if (i == 5) check("t2_af_at6", int'(almost_full), 1);
      end
      check("t2_full", int'(full), 1);
      check("t2_level8", int'(level), 8);
      step(1, 8'hFF, 0, 0, 0);
      check("t2_overflow", int'(overflow), 1);
      check("t2_level_hold", int'(level), 8);
      for (int i = 0; i < 8; i++) begin
         step(0, 8'h00, 1, 0, 0);
         check("t2_rd_valid", int'(rd_valid), 1);
         check("t2_rd_data", int'(data_out), 'h10 + i);
      end
      step(0, 8'h00, 0, 1, 0);
      check("t2_rd_valid_idle", int'(rd_valid), 0);
      check("t2_empty", int'(empty), 1);
      check("t2_ov_cleared", int'(overflow), 0);

      for (int i = 0; i < 5; i++) step(1, 8'(8'h20 + i), 0, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 8'h00, 1, 0, 0);
      for (int i = 0; i < 6; i++) step(1, 8'(8'hA0 + i), 0, 0, 0);
      for (int i = 0; i < 6; i++) begin
         step(0, 8'h00, 1, 0, 0);
         check("t3_wrap_data", int'(data_out), 'hA0 + i);
      end
      check("t3_level0", int'(level), 0);
      check("t3_no_ov", int'(overflow), 0);
      check("t3_no_un", int'(underflow), 0);

      for (int i = 0; i < 3; i++) step(1, 8'(8'h30 + i), 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         step(1, 8'(8'h40 + i), 1, 0, 0);
         check("t4_level3", int'(level), 3);
         check("t4_order", int'(data_out), (i < 3) ? ('h30 + i) : 'h40);
      end
      for (int i = 0; i < 3; i++) begin
         step(0, 8'h00, 1, 0, 0);
         check("t4_drain", int'(data_out), 'h41 + i);
      end
      step(1, 8'h50, 1, 0, 0);
      check("t4_un_set", int'(underflow), 1);
      check("t4_level1", int'(level), 1);
      step(0, 8'h00, 1, 0, 0);
      check("t4_data50", int'(data_out), 'h50);

      step(0, 8'h00, 1, 1, 0);
      check("t5_set_wins", int'(underflow), 1);
      step(0, 8'h00, 0, 1, 0);
      check("t5_cleared", int'(underflow), 0);
      for (int i = 0; i < 4; i++) step(1, 8'(8'h60 + i), 0, 0, 0);
      check("t5_level4", int'(level), 4);
      step(0, 8'h00, 0, 0, 1);
      check("t5_rst_level", int'(level), 0);
      check("t5_rst_empty", int'(empty), 1);
`endif

      for (int ph = 0; ph < 4; ph++) begin
         for (int n = 0; n < 500; n++) begin
            bit w, r, c, rs;
            w  = ($urandom_range(0, 99) < ((ph % 2 == 0) ? 75 : 35));
            r  = ($urandom_range(0, 99) < ((ph % 2 == 0) ? 35 : 75));
            c  = ($urandom_range(0, 19) == 0);
            rs = ($urandom_range(0, 249) == 0);
            step(w, 8'($urandom), r, c, rs);
         end
      end

      step(0, 8'h00, 0, 0, 0);
      check_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
